// File: rtl/microtile_sched_pkg.sv
// Shared types and constants for the microtile scheduler.
package microtile_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int CNT_W       = 8;
  localparam int N_TILES_DEF = 4;

endpackage

// File: rtl/microtile_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit after ptr, ascending with wrap.
module rr_arbiter #(
  parameter int N_TILES = 4,
  parameter int IDX_W   = $clog2(N_TILES)
) (
  input  logic [N_TILES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_TILES-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int i = 0; i < N_TILES; i++) begin
      // ptr < N_TILES, so a single conditional subtract gives the modulo
      cand = {1'b0, ptr} + (IDX_W+1)'(i + 1);
      if (cand >= (IDX_W+1)'(N_TILES))
        cand = cand - (IDX_W+1)'(N_TILES);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid      = 1'b1;
        winner_idx = cand[IDX_W-1:0];
      end
    end
    if (valid)
      winner[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/microtile_scheduler.sv
// Round-robin scheduler granting one microtile the shared output bus for a bounded tenure.
module microtile_scheduler
  import microtile_sched_pkg::*;
#(
  parameter int N_TILES = N_TILES_DEF,
  parameter int DWELL   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_TILES-1:0]     req,
  input  logic [8*N_TILES-1:0]   tile_out,
  output logic [N_TILES-1:0]     grant,
  output logic [7:0]             uo_out,
  output logic                   busy,
  output logic [7:0]             grant_count
);

  localparam int IDX_W = $clog2(N_TILES);

  state_t             state, state_nxt;
  logic [N_TILES-1:0] grant_nxt, arb_winner;
  logic [IDX_W-1:0]   last_grant, last_nxt, arb_idx;
  logic               arb_valid, start;
  logic [CNT_W-1:0]   cnt, cnt_nxt, count_nxt;

  rr_arbiter #(.N_TILES(N_TILES), .IDX_W(IDX_W)) u_arb (
    .req        (req),
    .ptr        (last_grant),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      last_grant  <= IDX_W'(N_TILES - 1);
      cnt         <= '0;
      grant_count <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_nxt;
      cnt         <= cnt_nxt;
      grant_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    cnt_nxt   = cnt;
    count_nxt = grant_count;
    start     = 1'b0;
    case (state)
      S_IDLE, S_GAP: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
        start     = ena && arb_valid;
      end
      S_GRANT: begin
        // Any exit condition, alone or combined, yields a single GAP entry
        if (cnt == '0 || !req[last_grant] || !ena) begin
          state_nxt = S_GAP;
          grant_nxt = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
    if (start) begin
      state_nxt = S_GRANT;
      grant_nxt = arb_winner;
      last_nxt  = arb_idx;
      cnt_nxt   = CNT_W'(DWELL - 1);
      count_nxt = grant_count + CNT_W'(1);
    end
  end

  assign busy   = (state == S_GRANT);
  assign uo_out = busy ? tile_out[{last_grant, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_microtile_scheduler.sv
// Directed bench for microtile_scheduler with a tenure scoreboard (DWELL=4, four tiles).
module tb_microtile_scheduler;

  localparam int NT = 4;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              rst_n, ena;
  logic [NT-1:0]     req;
  logic [8*NT-1:0]   tile_out;
  logic [NT-1:0]     grant;
  logic [7:0]        uo_out;
  logic              busy;
  logic [7:0]        grant_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         idx;
    logic [7:0] cnt;
    int         len;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  microtile_scheduler #(.N_TILES(NT), .DWELL(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req         (req),
    .tile_out    (tile_out),
    .grant       (grant),
    .uo_out      (uo_out),
    .busy        (busy),
    .grant_count (grant_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int cnt, input int len);
    exp_t e;
    e.idx = idx;
    e.cnt = 8'(cnt);
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Waits for a tenure to begin and compares it with the oldest scoreboard entry.
  task automatic start_check(output exp_t e);
    int         t;
    logic [7:0] b;
    t = 0;
    while (grant === '0 && t < 60) begin
      step(1);
      t++;
    end
    chk("grant_timeout", 32'(t < 60), 1);
    chk("sb_pending", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.idx = 0;
      e.cnt = 8'h00;
      e.len = 0;
    end
    chk("grant_onehot", 32'(grant), 32'(1) << e.idx);
    chk("grant_count", 32'(grant_count), 32'(e.cnt));
    chk("busy_grant", 32'(busy), 1);
    b = (e.idx == 2) ? 8'hA5 : 8'($urandom);
    tile_out[8*e.idx +: 8] = b;
    #1;
    chk("uo_live", 32'(uo_out), 32'(b));
  endtask

  task automatic tenure(input int act_at, input logic [NT-1:0] act_req, input logic act_ena);
    exp_t          e;
    int            len;
    logic [NT-1:0] cur;
    start_check(e);
    cur = grant;
    len = 1;
    if (act_at == 1) begin
      req = act_req;
      ena = act_ena;
    end
    while (len < 300) begin
      step(1);
      if (grant !== cur) break;
      chk("busy_hold", 32'(busy), 1);
      len++;
      if (len == act_at) begin
        req = act_req;
        ena = act_ena;
      end
    end
    chk("tenure_len", 32'(len), 32'(e.len));
    chk("gap_grant", 32'(grant), 0);
    chk("gap_busy", 32'(busy), 0);
    chk("gap_uo", 32'(uo_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    ena      = 1'b0;
    req      = '0;
    tile_out = 32'h44332211;

    // Reset state
    step(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_uo", 32'(uo_out), 0);
    chk("rst_count", 32'(grant_count), 0);
    rst_n = 1'b1;
    step(1);
    chk("idle_grant", 32'(grant), 0);

    // All tiles requesting: strict rotation from tile 0
    ena = 1'b1;
    req = 4'b1111;
    push(0, 1, 4); push(1, 2, 4); push(2, 3, 4); push(3, 4, 4); push(0, 5, 4);
    repeat (5) tenure(0, 4'b1111, 1'b1);
    req = '0;
    step(1);
    chk("idle_after_rot", 32'(busy), 0);
    chk("idle_grant_rot", 32'(grant), 0);

    // Granted request dropped in the third grant cycle
    req = 4'b0010;
    push(1, 6, 3);
    tenure(3, 4'b0000, 1'b1);
    step(1);
    chk("idle_after_drop", 32'(busy), 0);
    chk("idle_grant_drop", 32'(grant), 0);

    // Enable dropped in the second grant cycle; no grant until it returns
    req = 4'b0001;
    push(0, 7, 2);
    tenure(2, 4'b0001, 1'b0);
    step(1);
    chk("idle_after_ena", 32'(busy), 0);
    repeat (3) begin
      step(1);
      chk("ena_block", 32'(grant), 0);
    end
    ena = 1'b1;
    // Lone requester is re-granted; other req changes mid-tenure wait for GAP
    push(0, 8, 4); push(0, 9, 4); push(3, 10, 0);
    tenure(0, 4'b0001, 1'b1);
    tenure(2, 4'b1001, 1'b1);

    // Asynchronous reset in the middle of tile 3's tenure
    start_check(e);
    step(1);
    chk("t3_second", 32'(grant), 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_uo", 32'(uo_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(grant_count), 0);
    step(1);
    rst_n = 1'b1;
    req   = 4'b1001;
    push(0, 1, 4); push(3, 2, 4);
    tenure(0, 4'b1001, 1'b1);
    tenure(0, 4'b1001, 1'b1);

    // Run tenures until grant_count wraps
    req = 4'b1111;
    for (int k = 3; k <= 256; k++) begin
      push((k - 3) % 4, k, 4);
      tenure(0, 4'b1111, 1'b1);
    end
    chk("count_wrap", 32'(grant_count), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
